// File: rtl/disp_pkg.sv
// Shared constants and FSM encoding for the display frame fetcher.
package disp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ADDR = 2'd2,
    S_DATA = 2'd3
  } state_t;

  localparam int BURST_BEATS  = 16;
  localparam int BURST_BYTES  = 128;
  localparam int PIX_PER_BEAT = 2;
  localparam logic [7:0] ARLEN_VAL = 8'(BURST_BEATS - 1);

endpackage

// File: rtl/disp_fetch.sv
// Frame fetcher: streams one frame from memory as 16-beat AXI read bursts into the display buffer.
// Optional late-frame detection is built when DISP_FETCH_LATE_EN is defined.
module disp_fetch
  import disp_pkg::*;
#(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        DISPON,
  input  logic        VSTART,
  input  logic [31:0] DISPADDR,
  input  logic        BUF_WREADY,
  output logic [31:0] ARADDR,
  output logic [7:0]  ARLEN,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [63:0] RDATA,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [63:0] FIFOIN,
  output logic        FIFOWR,
  output logic        FIFORST,
  output logic        FETCH_LATE
);

  localparam int BURSTS = H_PIXELS * V_LINES / (PIX_PER_BEAT * BURST_BEATS);
  localparam int CNT_W  = $clog2(BURSTS + 1);

  state_t             r_state, w_next;
  logic [24:0]        r_base;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_stop;
  logic               r_fiforst;
  logic               r_fifowr;
  logic [63:0]        r_fifoin;
  logic               w_start, w_beat, w_end, w_last, w_stop, w_rready;
  logic               w_unused;

  assign w_unused = ^DISPADDR[6:0];

  assign w_start  = (r_state == S_IDLE) && VSTART && DISPON;
  assign w_rready = (r_state == S_DATA);
  assign w_beat   = RVALID && w_rready;
  assign w_end    = w_beat && RLAST;
  assign w_last   = (r_cnt == CNT_W'(BURSTS - 1));
  // A DISPON drop anywhere inside a burst ends the frame once that burst drains.
  assign w_stop   = r_stop || !DISPON;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_WAIT;
      S_WAIT: begin
        if (!DISPON)         w_next = S_IDLE;
        else if (BUF_WREADY) w_next = S_ADDR;
      end
      S_ADDR: if (ARREADY) w_next = S_DATA;
      S_DATA: if (w_end) w_next = (w_last || w_stop) ? S_IDLE : S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_cnt     <= '0;
      r_stop    <= 1'b0;
      r_fiforst <= 1'b0;
      r_fifowr  <= 1'b0;
      r_fifoin  <= '0;
    end else begin
      r_state   <= w_next;
      r_fiforst <= w_start;
      r_fifowr  <= w_beat;
      if (w_beat) r_fifoin <= RDATA;
      if (w_start) begin
        r_base <= DISPADDR[31:7];
        r_cnt  <= '0;
      end else if (w_end) begin
        r_cnt  <= r_cnt + 1'b1;
      end
      if (r_state == S_IDLE)
        r_stop <= 1'b0;
      else if ((r_state == S_ADDR || r_state == S_DATA) && !DISPON)
        r_stop <= 1'b1;
    end
  end

`ifdef DISP_FETCH_LATE_EN
  logic r_late;
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST)                              r_late <= 1'b0;
    else if (!DISPON)                      r_late <= 1'b0;
    else if (VSTART && r_state != S_IDLE)  r_late <= 1'b1;
  end
  assign FETCH_LATE = r_late;
`else
  assign FETCH_LATE = 1'b0;
`endif

  // Address is derived from registered state only, so it holds while ARVALID waits.
  assign ARADDR  = {r_base, 7'd0} + (32'(r_cnt) * 32'(BURST_BYTES));
  assign ARLEN   = ARLEN_VAL;
  assign ARVALID = (r_state == S_ADDR);
  assign RREADY  = w_rready;
  assign FIFOIN  = r_fifoin;
  assign FIFOWR  = r_fifowr;
  assign FIFORST = r_fiforst;

endmodule

// File: tb/tb_disp_fetch.sv
// Self-checking bench for disp_fetch: table of frame scenarios plus reset-mid-burst sequence.
module tb_disp_fetch;

`ifdef DISP_FETCH_LATE_EN
  localparam bit LATE_EN = 1'b1;
`else
  localparam bit LATE_EN = 1'b0;
`endif

  logic        ACLK = 1'b0, ARST = 1'b1;
  logic        DISPON = 1'b0, VSTART = 1'b0, BUF_WREADY = 1'b1;
  logic [31:0] DISPADDR = '0;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic        ARVALID, ARREADY = 1'b0;
  logic [63:0] RDATA = '0;
  logic        RLAST = 1'b0, RVALID = 1'b0, RREADY;
  logic [63:0] FIFOIN;
  logic        FIFOWR, FIFORST, FETCH_LATE;

  disp_fetch #(.H_PIXELS(64), .V_LINES(2)) dut (
    .ACLK(ACLK), .ARST(ARST), .DISPON(DISPON), .VSTART(VSTART), .DISPADDR(DISPADDR),
    .BUF_WREADY(BUF_WREADY), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID),
    .ARREADY(ARREADY), .RDATA(RDATA), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .FIFOIN(FIFOIN), .FIFOWR(FIFOWR), .FIFORST(FIFORST), .FETCH_LATE(FETCH_LATE)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] base;
    int ar_dly;      // -1: random 0..5
    int rv_mode;     // 0 back-to-back, 1 every other cycle, 2 random
    int stall_b;     // burst preceded by 50 cycles of BUF_WREADY=0, -1 none
    int drop_b;      // burst during whose beat 5 DISPON drops, -1 none
    int late_b;      // burst during which VSTART pulses, -1 none
    int exp_bursts;
    int exp_wr;
  } vec_t;

  typedef struct { logic [63:0] d; int c; } beat_t;

  int    n_cmp = 0, n_fail = 0, n_wr = 0, cyc = 0;
  beat_t exp_q[$];

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Buffer-write monitor: each accepted beat must appear once, in order, one cycle later.
  always @(negedge ACLK) begin
    if (!ARST && FIFOWR) begin
      n_wr++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL fifo_extra: got %h, want no write", FIFOIN);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        if (FIFOIN !== e.d || cyc != e.c + 1) begin
          n_fail++;
          $display("FAIL fifo_data: got %h @%0d, want %h @%0d", FIFOIN, cyc, e.d, e.c + 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic wait_ar(input string name, output bit ok);
    int t = 0;
    while (!ARVALID && t < 100) begin tick(); t++; end
    ok = ARVALID;
    chk(name, ARVALID, 1'b1);
  endtask

  task automatic run_burst(input vec_t v, input int b, output bit ok);
    logic [31:0] exp_a, a0;
    bit stable = 1;
    int dly, k = 0, c = 0;
    bit rv;
    beat_t e;
    exp_a = (v.base & 32'hFFFF_FF80) + 32'(b) * 32'd128;
    if (b == v.stall_b) begin
      bit seen = 0;
      repeat (50) begin if (ARVALID) seen = 1; tick(); end
      chk($sformatf("stall_ar_b%0d", b), seen, 1'b0);
      BUF_WREADY = 1'b1;
      tick();
      chk($sformatf("stall_release_b%0d", b), ARVALID, 1'b1);
    end
    wait_ar($sformatf("arvalid_b%0d", b), ok);
    if (!ok) return;
    chk($sformatf("araddr_b%0d", b), ARADDR, exp_a);
    chk("arlen", ARLEN, 8'd15);
    a0 = ARADDR;
    dly = (v.ar_dly < 0) ? int'($urandom_range(0, 5)) : v.ar_dly;
    repeat (dly) begin
      tick();
      if (!ARVALID || ARADDR !== a0) stable = 0;
    end
    chk($sformatf("ar_stable_b%0d", b), stable, 1'b1);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    chk($sformatf("rready_b%0d", b), RREADY, 1'b1);
    while (k < 16 && c < 200) begin
      case (v.rv_mode)
        0:       rv = 1'b1;
        1:       rv = (c % 2 == 0);
        default: rv = ($urandom_range(0, 2) != 0);
      endcase
      VSTART = (b == v.late_b && c == 0);
      if (b == v.drop_b && k == 4 && rv) DISPON = 1'b0;
      RVALID = rv;
      RDATA  = {$urandom, $urandom};
      RLAST  = rv && (k == 15);
      if (rv) begin
        e.d = RDATA; e.c = cyc;
        exp_q.push_back(e);
        if (k == 15 && b + 1 == v.stall_b) BUF_WREADY = 1'b0;
      end
      tick();
      if (rv) k++;
      c++;
    end
    RVALID = 1'b0; RLAST = 1'b0; VSTART = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int wr0;
    bit ok, seen;
    wr0 = n_wr;
    DISPADDR = v.base; DISPON = 1'b1; VSTART = 1'b1;
    tick();
    VSTART = 1'b0;
    chk($sformatf("v%0d_fiforst_hi", idx), FIFORST, 1'b1);
    tick();
    chk($sformatf("v%0d_fiforst_lo", idx), FIFORST, 1'b0);
    for (int b = 0; b < v.exp_bursts; b++) begin
      run_burst(v, b, ok);
      if (!ok) break;
    end
    seen = 0;
    repeat (30) begin if (ARVALID || RREADY) seen = 1; tick(); end
    chk($sformatf("v%0d_idle_after", idx), seen, 1'b0);
    chk($sformatf("v%0d_wr_count", idx), n_wr - wr0, v.exp_wr);
    chk($sformatf("v%0d_q_drained", idx), exp_q.size(), 0);
    chk($sformatf("v%0d_late", idx), FETCH_LATE, (v.late_b >= 0) && LATE_EN);
    DISPON = 1'b0;
    tick();
    chk($sformatf("v%0d_late_clr", idx), FETCH_LATE, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v;
    bit ok;
    beat_t e;
    vecs[0] = '{32'h2000_0000,  0, 0, -1, -1, -1, 4, 64};
    vecs[1] = '{32'h2000_0000,  0, 0,  2, -1, -1, 4, 64};
    vecs[2] = '{32'h3000_0045,  7, 1, -1, -1, -1, 4, 64};
    vecs[3] = '{32'h2000_0000,  0, 0, -1,  1, -1, 2, 32};
    vecs[4] = '{32'h4000_0000,  0, 0, -1, -1,  2, 4, 64};
    vecs[5] = '{32'hFFFF_FF80, -1, 2, -1, -1, -1, 4, 64};
    vecs[6] = '{$urandom,      -1, 2, -1, -1, -1, 4, 64};
    vecs[7] = '{$urandom,      -1, 2, -1, -1,  1, 4, 64};

    #1;
    chk("rst_arvalid", ARVALID, 1'b0);
    chk("rst_rready",  RREADY,  1'b0);
    chk("rst_fifowr",  FIFOWR,  1'b0);
    chk("rst_fifoin",  FIFOIN,  64'd0);
    chk("rst_fiforst", FIFORST, 1'b0);
    chk("rst_araddr",  ARADDR,  32'd0);
    chk("rst_late",    FETCH_LATE, 1'b0);
    repeat (3) tick();
    ARST = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset asserted mid-burst: outputs clear immediately, next frame restarts at burst 0.
    DISPADDR = 32'h5000_0000; DISPON = 1'b1; VSTART = 1'b1;
    tick();
    VSTART = 1'b0;
    wait_ar("rstmid_arvalid", ok);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      RVALID = 1'b1; RDATA = {$urandom, $urandom};
      e.d = RDATA; e.c = cyc;
      exp_q.push_back(e);
      tick();
    end
    #2 ARST = 1'b1;
    #1;
    chk("rstmid_arvalid0", ARVALID, 1'b0);
    chk("rstmid_rready0",  RREADY,  1'b0);
    chk("rstmid_fifowr0",  FIFOWR,  1'b0);
    chk("rstmid_fifoin0",  FIFOIN,  64'd0);
    chk("rstmid_araddr0",  ARADDR,  32'd0);
    RVALID = 1'b0;
    repeat (2) tick();
    ARST = 1'b0;
    exp_q.delete();
    tick();
    v = '{32'h6000_0000, 1, 0, -1, -1, -1, 4, 64};
    run_vec(v, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_fetch.md
DISP_FETCH -- requirements
Module: disp_fetch

Interface
REQ-001 Parameter H_PIXELS, default 640, active pixels per line.
REQ-002 Parameter V_LINES, default 480, active lines per frame.
REQ-003 ACLK  input  1  system clock; the only clock of the block.
REQ-004 ARST  input  1  reset, asynchronous, active-high.
REQ-005 DISPON  input  1  display enable; 0 stops fetching at the next burst boundary.
REQ-006 VSTART  input  1  one-cycle frame-start pulse, ACLK domain.
REQ-007 DISPADDR  input  32  frame base byte address; bits [6:0] ignored (128-byte aligned).
REQ-008 BUF_WREADY  input  1  display buffer has at least 256 free entries.
REQ-009 ARADDR  output  32  AXI read address.
REQ-010 ARLEN  output  8  AXI burst length, constant 8'd15.
REQ-011 ARVALID  output  1 / ARREADY  input  1  AXI read-address handshake.
REQ-012 RDATA  input  64 / RLAST  input  1 / RVALID  input  1 / RREADY  output  1  AXI read data.
REQ-013 FIFOIN  output  64  pixel-pair word to the display buffer.
REQ-014 FIFOWR  output  1  write strobe for FIFOIN.
REQ-015 FIFORST  output  1  one-cycle display-buffer reset at frame start.
REQ-016 FETCH_LATE  output  1  sticky flag: frame start arrived before the previous frame finished.

Function
REQ-017 Each 64-bit beat carries 2 pixels; each burst is 16 beats (128 bytes); bursts per frame = H_PIXELS*V_LINES/32 (9600 at defaults).
REQ-018 FSM states: IDLE, WAIT, ADDR, DATA.
REQ-019 IDLE: VSTART=1 with DISPON=1 latches DISPADDR[31:7], clears the burst counter, drives FIFORST=1 for exactly that next cycle, goes to WAIT.
REQ-020 WAIT: BUF_WREADY=1 and DISPON=1 -> ADDR; DISPON=0 -> IDLE; otherwise stay.
REQ-021 ADDR: ARVALID=1, ARADDR = base + 128*burst_count; ARVALID and ARADDR hold stable until ARREADY=1, then -> DATA.
REQ-022 DATA: RREADY=1; on RVALID&RLAST, burst_count increments; last burst of frame -> IDLE, else -> WAIT.
REQ-023 RREADY=0 and ARVALID=0 in all states other than DATA and ADDR respectively.
REQ-024 FIFOIN/FIFOWR are registered: FIFOWR=1 and FIFOIN=RDATA one cycle after each RVALID&RREADY beat; FIFOWR=0 otherwise.
REQ-025 DISPON falling during ADDR or DATA completes the current burst (address and all 16 beats) before returning to IDLE; no new burst is issued.
REQ-026 VSTART in any state other than IDLE is ignored for fetching and sets FETCH_LATE (when enabled).
REQ-027 Address arithmetic is 32-bit modulo 2^32; wrap-around is not checked.
REQ-028 RLAST is the only burst terminator; beat count is not checked against ARLEN.

Reset
REQ-029 ARST=1 asynchronously forces IDLE, burst_count=0, ARVALID=0, RREADY=0, FIFOWR=0, FIFOIN=0, FIFORST=0, ARADDR=0, FETCH_LATE=0.
REQ-030 Reset mid-burst abandons the transaction; the interconnect is reset by the same ARST.

Configuration
REQ-031 With DISP_FETCH_LATE_EN defined, FETCH_LATE sets on REQ-026 and clears when DISPON=0.
REQ-032 Without DISP_FETCH_LATE_EN, FETCH_LATE is tied 0 and no detection logic is built.

Structure
REQ-033 Shared package disp_pkg holds the FSM state encoding, BURST_BEATS=16, BURST_BYTES=128, PIX_PER_BEAT=2.
REQ-034 Single module; no sub-modules.

Verification
REQ-035 Reset then VSTART with DISPON=1, DISPADDR=32'h2000_0000, H_PIXELS=64, V_LINES=2 -> FIFORST 1 cycle, 4 bursts at 2000_0000/0080/0100/0180, 64 FIFOWR pulses, return to IDLE.
REQ-036 BUF_WREADY=0 for 50 cycles before burst 2 -> ARVALID stays 0 for those 50 cycles; burst 2 issues the cycle after BUF_WREADY=1.
REQ-037 ARREADY delayed 7 cycles, RVALID toggled every other cycle -> ARADDR stable throughout, FIFOIN equals each RDATA, one cycle later, in order.
REQ-038 DISPON=0 during beat 5 of burst 1 -> remaining 11 beats accepted and written, no further ARVALID, FSM in IDLE.
REQ-039 VSTART again during burst 2 -> fetch unaffected; FETCH_LATE=1 with DISP_FETCH_LATE_EN, 0 without; cleared when DISPON=0.
REQ-040 ARST pulsed mid-DATA -> all outputs at reset values in the same cycle; next VSTART restarts from burst 0.
